// File: rtl/id_ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the ID->EX operand stage: default datapath,
//   register-index and counter widths, the index of the hardwired zero
//   register, and the operand forward-select encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;
    localparam int CW_DEFAULT = 32;

    // Register 0 always reads as zero and is never a real producer.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Valid/ready bus from the operand stage to the EX stage.
//   master : the operand stage (drives valid and the captured payload)
//   slave  : the EX stage (drives ready)
//   Signals:
//     valid          payload holds a live instruction
//     ready          EX consumes the payload this cycle
//     op_a, op_b     already-forwarded operands
//     rs, rt, rd     captured register indices
//     regw, memread  captured control (0 whenever valid is 0)
//     imm            captured sign-extended immediate
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int DW = pipe_pkg::DW_DEFAULT,
    parameter int AW = pipe_pkg::AW_DEFAULT
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          regw;
    logic          memread;
    logic [DW-1:0] imm;

    modport master (
        output valid, op_a, op_b, rs, rt, rd, regw, memread, imm,
        input  ready
    );

    modport slave (
        input  valid, op_a, op_b, rs, rt, rd, regw, memread, imm,
        output ready
    );

endinterface

// File: rtl/id_ex_operand_stage_bypass.sv
// ---------------------------------------------------------------------------
// operand_bypass
//   Hazard detection and forward selection for a single source operand.
//   Purely combinational.
//   Ports:
//     useSrc        instruction actually reads this source
//     src           source register index
//     rfData        register-file read data for src
//     exValid/exRegw/exRd              producer currently held in EX
//     exmemRegw/exmemMemread/exmemRd/exmemResult   EX/MEM producer
//     memwbRegw/memwbRd/memwbData      MEM/WB producer (regfile write port)
//     hazard        operand cannot be bypassed this cycle; ID must stall
//     operand       forwarded operand value
// ---------------------------------------------------------------------------
module operand_bypass
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          useSrc,
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] rfData,
    input  logic          exValid,
    input  logic          exRegw,
    input  logic [AW-1:0] exRd,
    input  logic          exmemRegw,
    input  logic          exmemMemread,
    input  logic [AW-1:0] exmemRd,
    input  logic [DW-1:0] exmemResult,
    input  logic          memwbRegw,
    input  logic [AW-1:0] memwbRd,
    input  logic [DW-1:0] memwbData,
    output logic          hazard,
    output logic [DW-1:0] operand
);

    logic     live;
    logic     hitEx;
    logic     hitExmem;
    logic     hitMemwb;
    fwd_sel_t fwdSel;

    // Match the source against every in-flight producer. A producer still in
    // EX has no result yet, and a load in EX/MEM only has an address, so both
    // force a stall. Otherwise the youngest available result wins; MEM/WB is
    // still needed because the regfile is written at the same edge and the
    // read in this cycle returns the old value. Register 0 never matches.
    always_comb begin
        live     = useSrc && (src != AW'(REG_ZERO));
        hitEx    = live && exValid && exRegw && (exRd == src);
        hitExmem = live && exmemRegw && (exmemRd == src);
        hitMemwb = live && memwbRegw && (memwbRd == src);
        hazard   = hitEx || (hitExmem && exmemMemread);

        fwdSel = FWD_RF;
        if (hitExmem && !exmemMemread) begin
            fwdSel = FWD_EXMEM;
        end else if (hitMemwb) begin
            fwdSel = FWD_MEMWB;
        end

        case (fwdSel)
            FWD_EXMEM: operand = exmemResult;
            FWD_MEMWB: operand = memwbData;
            default:   operand = rfData;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID->EX pipeline register. Forwards EX/MEM and MEM/WB results into the
//   register-file operands, stalls decode when a bypass is impossible, and
//   hands the captured instruction to EX over a valid/ready bus.
//   Ports:
//     clk, reset (async, active low)
//     id_valid/id_ready                 decode handshake
//     id_rs, id_rt, id_use_rs, id_use_rt, id_data1, id_data2
//     id_rd, id_regw, id_memread, id_imm  decoded instruction
//     exmem_regw/memread/rd/result      EX/MEM producer
//     memwb_regw/rd/data                MEM/WB producer
//     flush                             kill held and incoming instruction
//     ex                                bus to EX (master side)
//     stall_cycles                      saturating hazard-stall counter
// ---------------------------------------------------------------------------
module id_ex_operand_stage
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [DW-1:0] id_data1,
    input  logic [DW-1:0] id_data2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regw,
    input  logic          id_memread,
    input  logic [DW-1:0] id_imm,
    input  logic          exmem_regw,
    input  logic          exmem_memread,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regw,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    input  logic          flush,
    id_ex_operand_stage_if.master ex,
    output logic [CW-1:0] stall_cycles
);

    logic          advance;
    logic          stall;
    logic          hazA;
    logic          hazB;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;

    operand_bypass #(.DW(DW), .AW(AW)) bypassRs (
        .useSrc(id_use_rs), .src(id_rs), .rfData(id_data1),
        .exValid(ex.valid), .exRegw(ex.regw), .exRd(ex.rd),
        .exmemRegw(exmem_regw), .exmemMemread(exmem_memread),
        .exmemRd(exmem_rd), .exmemResult(exmem_result),
        .memwbRegw(memwb_regw), .memwbRd(memwb_rd), .memwbData(memwb_data),
        .hazard(hazA), .operand(opA)
    );

    operand_bypass #(.DW(DW), .AW(AW)) bypassRt (
        .useSrc(id_use_rt), .src(id_rt), .rfData(id_data2),
        .exValid(ex.valid), .exRegw(ex.regw), .exRd(ex.rd),
        .exmemRegw(exmem_regw), .exmemMemread(exmem_memread),
        .exmemRd(exmem_rd), .exmemResult(exmem_result),
        .memwbRegw(memwb_regw), .memwbRd(memwb_rd), .memwbData(memwb_data),
        .hazard(hazB), .operand(opB)
    );

    // The register can move whenever it is empty or EX is taking its
    // contents. Decode is only accepted when it can move, no source is
    // blocked, and no redirect is killing the incoming instruction.
    always_comb begin
        advance  = !ex.valid || ex.ready;
        stall    = id_valid && (hazA || hazB);
        id_ready = advance && !stall && !flush;
    end

    // Pipeline register. A flush wins over everything, back-pressure holds
    // the payload, and a stall or idle decode inserts a bubble. Bubbles
    // clear the write-back and load flags so downstream hazard logic never
    // sees a phantom producer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex.valid   <= 1'b0;
            ex.op_a    <= '0;
            ex.op_b    <= '0;
            ex.rs      <= '0;
            ex.rt      <= '0;
            ex.rd      <= '0;
            ex.regw    <= 1'b0;
            ex.memread <= 1'b0;
            ex.imm     <= '0;
        end else if (flush) begin
            ex.valid   <= 1'b0;
            ex.regw    <= 1'b0;
            ex.memread <= 1'b0;
        end else if (advance) begin
            if (id_valid && !stall) begin
                ex.valid   <= 1'b1;
                ex.op_a    <= opA;
                ex.op_b    <= opB;
                ex.rs      <= id_rs;
                ex.rt      <= id_rt;
                ex.rd      <= id_rd;
                ex.regw    <= id_regw;
                ex.memread <= id_memread;
                ex.imm     <= id_imm;
            end else begin
                ex.valid   <= 1'b0;
                ex.regw    <= 1'b0;
                ex.memread <= 1'b0;
            end
        end
    end

    // Counts only stalls that actually cost a cycle: while EX back-pressures
    // or a flush is pending, decode would not have advanced anyway. The count
    // sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && advance && !flush && (stall_cycles != {CW{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Self-checking bench. The downstream pipeline (EX/MEM, MEM/WB) is driven
//   by hand cycle by cycle; expected EX payloads go into a scoreboard queue
//   when decode is expected to be accepted and are compared when EX takes
//   them. A second instance with a 2-bit counter checks saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [DW-1:0] opA;
        logic [DW-1:0] opB;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          regw;
        logic          memread;
        logic [DW-1:0] imm;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid, id_ready;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_use_rs, id_use_rt, id_regw, id_memread;
    logic [DW-1:0] id_data1, id_data2, id_imm;
    logic          exmem_regw, exmem_memread;
    logic [AW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_regw;
    logic [AW-1:0] memwb_rd;
    logic [DW-1:0] memwb_data;
    logic          flush;
    logic [31:0]   stall_cycles;
    logic          satIdReady;
    logic [1:0]    satStallCycles;

    int   compared = 0;
    int   mismatched = 0;
    txn_t sb[$];
    txn_t expTxn;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DW(DW), .AW(AW)) exIf ();
    id_ex_operand_stage_if #(.DW(DW), .AW(AW)) satIf ();

    assign satIf.ready = exIf.ready;

    id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_rd(id_rd), .id_regw(id_regw), .id_memread(id_memread), .id_imm(id_imm),
        .exmem_regw(exmem_regw), .exmem_memread(exmem_memread),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regw(memwb_regw), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .ex(exIf), .stall_cycles(stall_cycles)
    );

    id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(2)) satDut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(satIdReady),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_rd(id_rd), .id_regw(id_regw), .id_memread(id_memread), .id_imm(id_imm),
        .exmem_regw(exmem_regw), .exmem_memread(exmem_memread),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regw(memwb_regw), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .ex(satIf), .stall_cycles(satStallCycles)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic clearInputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_data1 = '0; id_data2 = '0; id_rd = '0; id_regw = 1'b0; id_memread = 1'b0;
        id_imm = '0; flush = 1'b0;
        exmem_regw = 1'b0; exmem_memread = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regw = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    // Drive a decoded instruction; the default expectation is no forwarding.
    task automatic setId(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic useRs, input logic useRt,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [AW-1:0] rd, input logic regw,
                         input logic memread, input logic [DW-1:0] imm);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = useRs; id_use_rt = useRt;
        id_data1 = d1; id_data2 = d2; id_rd = rd; id_regw = regw;
        id_memread = memread; id_imm = imm;
        expTxn = '{opA: d1, opB: d2, rs: rs, rt: rt, rd: rd, regw: regw,
                   memread: memread, imm: imm};
    endtask

    task automatic setExmem(input logic regw, input logic memread,
                            input logic [AW-1:0] rd, input logic [DW-1:0] result);
        exmem_regw = regw; exmem_memread = memread; exmem_rd = rd; exmem_result = result;
    endtask

    task automatic setMemwb(input logic regw, input logic [AW-1:0] rd,
                            input logic [DW-1:0] data);
        memwb_regw = regw; memwb_rd = rd; memwb_data = data;
    endtask

    // One cycle: called just after a negedge with inputs set. Samples outputs
    // mid-cycle, retires the EX payload if taken, records an accepted
    // instruction, then waits for the next negedge.
    task automatic applyStimulus(input logic expReady, input logic expValid);
        txn_t e;
        #1;
        checkOutput("id_ready", 32'(id_ready), 32'(expReady));
        checkOutput("ex_valid", 32'(exIf.valid), 32'(expValid));
        if (!exIf.valid) begin
            checkOutput("bubble_ctl", {30'b0, exIf.regw, exIf.memread}, 32'd0);
        end
        if (exIf.valid && exIf.ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("op_a", exIf.op_a, e.opA);
                checkOutput("op_b", exIf.op_b, e.opB);
                checkOutput("idx", {17'b0, exIf.rs, exIf.rt, exIf.rd},
                            {17'b0, e.rs, e.rt, e.rd});
                checkOutput("ctl", {30'b0, exIf.regw, exIf.memread},
                            {30'b0, e.regw, e.memread});
                checkOutput("imm", exIf.imm, e.imm);
            end
        end
        if (id_valid && expReady) begin
            sb.push_back(expTxn);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        exIf.ready = 1'b1;
        expTxn = '{default: '0};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ex_valid", 32'(exIf.valid), 32'd0);
        checkOutput("rst_stall_cnt", stall_cycles, 32'd0);
        reset = 1'b1;

        // Plain transactions, then async reset while EX holds one
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'h10, 32'h20, 5'd9, 1'b1, 1'b0, 32'h5);
        applyStimulus(1'b1, 1'b0);
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'h30, 32'h40, 5'd8, 1'b1, 1'b1, 32'hFFFF_FFF0);
        applyStimulus(1'b1, 1'b1);
        clearInputs();
        #2 reset = 1'b0;
        #1;
        checkOutput("async_ex_valid", 32'(exIf.valid), 32'd0);
        checkOutput("async_op_a", exIf.op_a, 32'd0);
        checkOutput("async_op_b", exIf.op_b, 32'd0);
        checkOutput("async_imm", exIf.imm, 32'd0);
        checkOutput("async_idx", {17'b0, exIf.rs, exIf.rt, exIf.rd}, 32'd0);
        checkOutput("async_ctl", {30'b0, exIf.regw, exIf.memread}, 32'd0);
        checkOutput("async_stall_cnt", stall_cycles, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);

        // ALU -> dependent: one bubble, then EX/MEM bypass
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'h50, 32'h5A, 5'd3, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0);
        setId(5'd3, 5'd1, 1'b1, 1'b1, 32'h0, 32'h77, 5'd4, 1'b1, 1'b0, 32'h1);
        applyStimulus(1'b0, 1'b1);
        setExmem(1'b1, 1'b0, 5'd3, 32'h0000_00AA);
        expTxn.opA = 32'h0000_00AA;
        applyStimulus(1'b1, 1'b0);
        checkOutput("alu_stall_cnt", stall_cycles, 32'd1);
        checkOutput("sat_cnt_1", 32'(satStallCycles), 32'd1);
        clearInputs();
        setMemwb(1'b1, 5'd3, 32'h0000_00AA);
        applyStimulus(1'b1, 1'b1);

        // Load -> dependent: two bubbles, then MEM/WB bypass
        clearInputs();
        setId(5'd2, 5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 32'h8);
        applyStimulus(1'b1, 1'b0);
        setId(5'd5, 5'd5, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 5'd6, 1'b1, 1'b0, 32'h2);
        applyStimulus(1'b0, 1'b1);
        setExmem(1'b1, 1'b1, 5'd5, 32'h999);
        applyStimulus(1'b0, 1'b0);
        setExmem(1'b0, 1'b0, 5'd0, 32'h0);
        setMemwb(1'b1, 5'd5, 32'h1234_5678);
        expTxn.opA = 32'h1234_5678;
        expTxn.opB = 32'h1234_5678;
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_stall_cnt", stall_cycles, 32'd3);
        checkOutput("sat_cnt_3", 32'(satStallCycles), 32'd3);
        clearInputs();
        applyStimulus(1'b1, 1'b1);

        // EX/MEM beats MEM/WB on the same index; r0 never forwards or stalls
        setId(5'd7, 5'd7, 1'b1, 1'b1, 32'h33, 32'h44, 5'd10, 1'b0, 1'b0, 32'h3);
        setExmem(1'b1, 1'b0, 5'd7, 32'h11);
        setMemwb(1'b1, 5'd7, 32'h22);
        expTxn.opA = 32'h11;
        expTxn.opB = 32'h11;
        applyStimulus(1'b1, 1'b0);
        setId(5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0, 32'h4);
        setExmem(1'b1, 1'b1, 5'd0, 32'h55);
        setMemwb(1'b1, 5'd0, 32'h66);
        applyStimulus(1'b1, 1'b1);
        checkOutput("r0_stall_cnt", stall_cycles, 32'd3);
        clearInputs();
        applyStimulus(1'b1, 1'b1);

        // EX back-pressure for three cycles, then release
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'hA1, 32'hA2, 5'd11, 1'b1, 1'b0, 32'h3);
        applyStimulus(1'b1, 1'b0);
        exIf.ready = 1'b0;
        setId(5'd4, 5'd6, 1'b1, 1'b1, 32'hB1, 32'hB2, 5'd12, 1'b1, 1'b0, 32'h6);
        repeat (3) applyStimulus(1'b0, 1'b1);
        exIf.ready = 1'b1;
        applyStimulus(1'b1, 1'b1);
        clearInputs();
        applyStimulus(1'b1, 1'b1);

        // Flush with a pending stall: bubble, counter untouched
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'hC1, 32'hC2, 5'd13, 1'b1, 1'b0, 32'h7);
        applyStimulus(1'b1, 1'b0);
        setId(5'd13, 5'd2, 1'b1, 1'b1, 32'hD1, 32'hD2, 5'd14, 1'b1, 1'b0, 32'h8);
        flush = 1'b1;
        applyStimulus(1'b0, 1'b1);
        clearInputs();
        applyStimulus(1'b1, 1'b0);
        checkOutput("flush_stall_cnt", stall_cycles, 32'd3);

        // Flush kills an instruction held under back-pressure
        setId(5'd1, 5'd2, 1'b1, 1'b1, 32'hE1, 32'hE2, 5'd16, 1'b1, 1'b1, 32'h9);
        applyStimulus(1'b1, 1'b0);
        clearInputs();
        exIf.ready = 1'b0;
        flush = 1'b1;
        applyStimulus(1'b0, 1'b1);
        void'(sb.pop_back());
        flush = 1'b0;
        exIf.ready = 1'b1;
        applyStimulus(1'b1, 1'b0);

        // Two more load-use stalls: 32-bit counter keeps counting, 2-bit sticks
        setId(5'd21, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd22, 1'b1, 1'b0, 32'h0);
        setExmem(1'b1, 1'b1, 5'd21, 32'h0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        clearInputs();
        applyStimulus(1'b1, 1'b0);
        checkOutput("more_stall_cnt", stall_cycles, 32'd5);
        checkOutput("sat_cnt_hold", 32'(satStallCycles), 32'd3);

        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
